// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART Tx among N_REQ byte sources.
// It captures the granted byte, issues a one-cycle send pulse, then locks out grants for one frame plus the gap.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         ack,
  output logic                     send,
  output logic [7:0]               data,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id
);
  localparam int GW        = $clog2(N_REQ);
  localparam int FRAME_CYC = CLKS_PER_BIT * FRAME_BITS;
  localparam int CNT_MAX   = (FRAME_CYC > GAP_CYCLES) ? FRAME_CYC : GAP_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [N_REQ-1:0]        ack_d;
  logic                    send_d;
  logic [7:0]              data_d;
  logic [GW-1:0]           gid_d, win, cand;
  logic [N_REQ-1:0][7:0]   bytes;

  assign bytes = req_data;

  // Scan downward from the farthest offset so the nearest requester after grant_id wins last.
  always_comb begin
    win  = grant_id;
    cand = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = GW'((int'(grant_id) + k) % N_REQ);
      if (req[cand]) win = cand;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    send_d  = 1'b0;
    ack_d   = '0;
    data_d  = data;
    gid_d   = grant_id;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = FRAME;
          cnt_d      = FRAME_LOAD;
          send_d     = 1'b1;
          ack_d[win] = 1'b1;
          data_d     = bytes[win];
          gid_d      = win;
        end
      end
      FRAME: begin
        if (cnt_q == '0) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      send     <= 1'b0;
      ack      <= '0;
      data     <= 8'h00;
      busy     <= 1'b0;
      grant_id <= GW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      send     <= send_d;
      ack      <= ack_d;
      data     <= data_d;
      busy     <= (state_d != IDLE);
      grant_id <= gid_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: default instance plus a CLKS_PER_BIT=1/GAP_CYCLES=0 instance on shared inputs,
// both checked every cycle against a grant-timeline model.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;

  logic [N-1:0] ack0, ack1;
  logic         send0, send1, busy0, busy1;
  logic [7:0]   data0, data1;
  logic [1:0]   gid0, gid1;

  uart_tx_arbiter #(.N_REQ(N)) u_dut0 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack0), .send(send0), .data(data0), .busy(busy0), .grant_id(gid0)
  );

  uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BIT(1), .FRAME_BITS(10), .GAP_CYCLES(0)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .ack(ack1), .send(send1), .data(data1), .busy(busy1), .grant_id(gid1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: a grant on edge t blocks sampling until edge t+SPACING, busy visible after edges t..t+SPACING-2.
  int           spacing [2] = '{4*10 + 2 + 1, 1*10 + 0 + 1};
  int           last_g  [2];
  int           next_s  [2];
  int           busy_end[2];
  logic [7:0]   m_data  [2];
  logic [N-1:0] m_ack   [2];
  logic         m_send  [2];

  logic [N-1:0] oneshot = '0;
  bit           rnd_data = 1'b0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, d, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_g[d]   = N - 1;
      next_s[d]   = 0;
      busy_end[d] = -10;
      m_data[d]   = 8'h00;
      m_ack[d]    = '0;
      m_send[d]   = 1'b0;
    end
    cyc = 0;
  endtask

  task automatic check_outputs();
    chk("send",     0, 32'(send0), 32'(m_send[0]));
    chk("ack",      0, 32'(ack0),  32'(m_ack[0]));
    chk("data",     0, 32'(data0), 32'(m_data[0]));
    chk("busy",     0, 32'(busy0), 32'(cyc <= busy_end[0]));
    chk("grant_id", 0, 32'(gid0),  32'(last_g[0]));
    chk("onehot",   0, 32'($countones(ack0) <= 1), 32'd1);
    chk("send",     1, 32'(send1), 32'(m_send[1]));
    chk("ack",      1, 32'(ack1),  32'(m_ack[1]));
    chk("data",     1, 32'(data1), 32'(m_data[1]));
    chk("busy",     1, 32'(busy1), 32'(cyc <= busy_end[1]));
    chk("grant_id", 1, 32'(gid1),  32'(last_g[1]));
    chk("onehot",   1, 32'($countones(ack1) <= 1), 32'd1);
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        m_send[d] = 1'b0;
        m_ack[d]  = '0;
        if (cyc >= next_s[d] && req != '0) begin
          int w = last_g[d];
          for (int k = N; k >= 1; k--)
            if (req[(last_g[d] + k) % N]) w = (last_g[d] + k) % N;
          m_send[d]   = 1'b1;
          m_ack[d]    = N'(1) << w;
          m_data[d]   = req_data[8*w +: 8];
          last_g[d]   = w;
          next_s[d]   = cyc + spacing[d];
          busy_end[d] = cyc + spacing[d] - 2;
        end
      end
      @(negedge clk);
      check_outputs();
      req = req & ~(m_ack[0] & oneshot);
      if (rnd_data) req_data = $urandom();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_send",  0, 32'(send0), 32'd0);
    chk("rst_ack",   0, 32'(ack0),  32'd0);
    chk("rst_data",  0, 32'(data0), 32'd0);
    chk("rst_busy",  0, 32'(busy0), 32'd0);
    chk("rst_gid",   0, 32'(gid0),  32'd3);
    chk("rst_send",  1, 32'(send1), 32'd0);
    chk("rst_busy",  1, 32'(busy1), 32'd0);
    chk("rst_gid",   1, 32'(gid1),  32'd3);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();

    // Single byte from requester 0
    req_data = 32'h13121141;
    req = 4'b0001; oneshot = 4'b0001;
    tick(50);

    // All four held: strict rotation, fixed bytes
    req_data = 32'h13121110;
    req = 4'b1111; oneshot = 4'b0000;
    tick(4*43 + 10);

    // req0 one-shot, req1 held, then req0 raised again mid-frame
    rnd_data = 1'b1;
    req = 4'b0011; oneshot = 4'b0001;
    tick(150);
    tick(10);
    req[0] = 1'b1;
    tick(100);

    // req2 rising at frame cycle 5
    req = 4'b0000; tick(60);
    req = 4'b0001; oneshot = 4'b0001;
    tick(6);
    req[2] = 1'b1; oneshot = 4'b0101;
    tick(60);

    // Reset mid-frame with req1 pending
    req = 4'b0000; oneshot = 4'b0000; tick(60);
    req = 4'b0001;
    tick(1);
    req = 4'b0000;
    tick(20);
    req = 4'b0010;
    do_reset();
    tick(10);
    chk("post_rst_gid", 0, 32'(gid0), 32'd1);

    // Random request patterns
    for (int i = 0; i < 30; i++) begin
      req     = N'($urandom_range(0, 15));
      oneshot = N'($urandom_range(0, 15));
      tick($urandom_range(1, 40));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
